instruction_loader: RTL

Boot-time writer for the 16-bit MIPS instruction memory. Accepts a byte stream (length header plus big-endian instruction words) over a valid/ready handshake, assembles 16-bit words, and issues one write per word at consecutive addresses from 0. Holds the CPU core in reset until the image is fully written. Sits between the external download link and the write port of the instruction memory; the CPU's combinational `pc`→`instruction` read path is untouched.

---
 rtl/mips_pkg.sv | 19 +
 rtl/instruction_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Parameters and types shared by the 16-bit MIPS core, its instruction memory
// and the boot-time instruction loader.
package mips_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 13;
    localparam int unsigned IMEM_DEPTH = 24;

    typedef enum logic [2:0] {
        LdIdle,
        LdLenHi,
        LdLenLo,
        LdDataHi,
        LdDataLo,
        LdDone,
        LdError
    } loader_state_e;

endpackage

// File: rtl/instruction_loader.sv
// Boot-time writer for the instruction memory: takes a length-prefixed big-endian byte
// stream and writes one 16-bit word per pair of bytes, holding the CPU in reset meanwhile.
module instruction_loader #(
    parameter int unsigned DEPTH  = mips_pkg::IMEM_DEPTH,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              cpu_rst_no
);

    import mips_pkg::*;

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    loader_state_e     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              accept;
    logic [15:0]       len_full;
    logic [15:0]       cnt_inc;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // in_ready_q mirrors the current state, so it doubles as the accept qualifier
        accept      = in_valid_i && in_ready_q;
        len_full    = {len_q[15:8], in_data_i};
        cnt_inc     = cnt_q + 16'd1;

        unique case (state_q)
            LdIdle, LdDone, LdError: begin
                if (start_i) begin
                    state_d    = LdLenHi;
                    cnt_d      = '0;
                    mem_addr_d = '0;
                end
            end
            LdLenHi: begin
                if (accept) begin
                    len_d[15:8] = in_data_i;
                    state_d     = LdLenLo;
                end
            end
            LdLenLo: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = LdDone;
                    end else if (len_full > DEPTH16) begin
                        state_d = LdError;
                    end else begin
                        state_d = LdDataHi;
                    end
                end
            end
            LdDataHi: begin
                if (accept) begin
                    hi_d    = in_data_i;
                    state_d = LdDataLo;
                end
            end
            LdDataLo: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = DATA_W'({hi_q, in_data_i});
                    cnt_d       = cnt_inc;
                    state_d     = (cnt_inc == len_q) ? LdDone : LdDataHi;
                end
            end
            default: state_d = LdIdle;
        endcase

        // Status outputs are registered from the next state so they line up with mem_we
        in_ready_d  = (state_d == LdLenHi) || (state_d == LdLenLo) ||
                      (state_d == LdDataHi) || (state_d == LdDataLo);
        busy_d      = in_ready_d;
        done_d      = (state_d == LdDone);
        error_d     = (state_d == LdError);
        cpu_rst_n_d = (state_d == LdDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LdIdle;
            len_q       <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign cpu_rst_no  = cpu_rst_n_q;

endmodule
